// File: rtl/mod_counter_pkg.sv
// Shared types and helpers for the modulus counter with BCD display output.
package mod_counter_pkg;

  // Sequential binary-to-BCD converter states.
  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } conv_state_e;

  // Width of one sseg_driver digit field: {enable, bcd[3:0], dp_n}.
  localparam int unsigned SSEG_FIELD_W = 6;

  // Smallest digit count n with 10**n > max_val.
  function automatic int unsigned min_digits(input int unsigned max_val);
    int unsigned n;
    logic [63:0] lim;
    n   = 1;
    lim = 64'd10;
    for (int i = 0; i < 19; i++) begin
      if (lim <= 64'(max_val)) begin
        n   = n + 1;
        lim = lim * 64'd10;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/mod_counter_bcd_if.sv
// Command and status bundle between the button front end, the counter and the display driver.
interface mod_counter_bcd_if
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);

  logic                           up;
  logic                           down;
  logic                           load;
  logic                           sat_mode;
  logic [WIDTH-1:0]               D;
  logic [WIDTH-1:0]               count;
  logic                           ovf;
  logic                           unf;
  logic [4*DIGITS-1:0]            bcd;
  logic                           bcd_valid;
  logic [SSEG_FIELD_W*DIGITS-1:0] digit_fields;

  // Command source (button side) and its view of the status.
  modport master (
    output up, down, load, sat_mode, D,
    input  count, ovf, unf, bcd, bcd_valid, digit_fields
  );

  // Counter side.
  modport slave (
    input  up, down, load, sat_mode, D,
    output count, ovf, unf, bcd, bcd_valid, digit_fields
  );

endinterface

// File: rtl/mod_counter_bcd_bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter; one bit per clock, MSB first.
module bin2bcd_seq
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    value,
  output logic [4*DIGITS-1:0] bcd,
  output logic                busy,
  output logic                match
);

  localparam int unsigned   CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  conv_state_e         state_q, state_d;
  logic [WIDTH-1:0]    snap_q, snap_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] acc_q, acc_d, acc_adj;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  // Add-3 correction on every nibble >= 5 ahead of the shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state: snapshot on change, shift WIDTH bits, publish once in StDone.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      StIdle: begin
        if (value != snap_q) begin
          snap_d  = value;
          bin_d   = value;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        {acc_d, bin_d} = {acc_adj, bin_q} << 1;
        cnt_d          = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Only here does bcd change, so partial shift results are never visible.
        bcd_d   = acc_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      snap_q  <= '0;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bcd   = bcd_q;
  assign busy  = (state_q != StIdle);
  assign match = (snap_q == value);

endmodule

// File: rtl/mod_counter_bcd.sv
// Up/down/load counter with programmable modulus, wrap/saturate, and BCD display fields.
module mod_counter_bcd
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX      = 255,
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned BLANK_LZ = 1
) (
  input logic              clk,
  input logic              rst,
  mod_counter_bcd_if.slave bus
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

  if (DIGITS < min_digits(MAX)) begin : g_digits_chk
    $error("mod_counter_bcd: DIGITS too small to display MAX");
  end
  if ((MAX < 1) || (64'(MAX) >= (64'd1 << WIDTH))) begin : g_max_chk
    $error("mod_counter_bcd: MAX outside 1..2**WIDTH-1");
  end

  logic [WIDTH-1:0]               count_q, count_d;
  logic                           ovf_q, ovf_d;
  logic                           unf_q, unf_d;
  logic [4*DIGITS-1:0]            bcd_w;
  logic                           conv_busy;
  logic                           conv_match;
  logic [DIGITS-1:0]              digit_en;
  logic [SSEG_FIELD_W*DIGITS-1:0] fields;
  logic                           seen_nz;

  // Counter next-state: load > (up & down hold) > up > down.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (bus.load) begin
      // Clamping an out-of-range load is not an overflow.
      count_d = (bus.D > MaxVal) ? MaxVal : bus.D;
    end else if (bus.up && bus.down) begin
      count_d = count_q;
    end else if (bus.up) begin
      if (count_q == MaxVal) begin
        ovf_d   = 1'b1;
        count_d = bus.sat_mode ? MaxVal : '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end else if (bus.down) begin
      if (count_q == '0) begin
        unf_d   = 1'b1;
        count_d = bus.sat_mode ? '0 : MaxVal;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  // Count and one-cycle flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .value (count_q),
    .bcd   (bcd_w),
    .busy  (conv_busy),
    .match (conv_match)
  );

  // Display fields: scan from the top digit so leading zeros can be blanked.
  always_comb begin
    seen_nz  = 1'b0;
    digit_en = '0;
    fields   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen_nz     = seen_nz | (|bcd_w[4*i +: 4]);
      digit_en[i] = (i == 0) || (BLANK_LZ == 0) || seen_nz;
      fields[SSEG_FIELD_W*i +: SSEG_FIELD_W] = {digit_en[i], bcd_w[4*i +: 4], 1'b1};
    end
  end

  assign bus.count        = count_q;
  assign bus.ovf          = ovf_q;
  assign bus.unf          = unf_q;
  assign bus.bcd          = bcd_w;
  assign bus.bcd_valid    = ~conv_busy & conv_match;
  assign bus.digit_fields = fields;

endmodule

// File: tb/tb_mod_counter_bcd.sv
// Bench for mod_counter_bcd: default instance (MAX=255) and a MAX=150 instance.
module tb_mod_counter_bcd;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mod_counter_bcd_if #(.WIDTH(8), .DIGITS(3)) bus_a ();
  mod_counter_bcd_if #(.WIDTH(8), .DIGITS(3)) bus_b ();

  mod_counter_bcd #(.WIDTH(8), .MAX(255), .DIGITS(3), .BLANK_LZ(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mod_counter_bcd #(.WIDTH(8), .MAX(150), .DIGITS(3), .BLANK_LZ(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] sb_q[$];

  // Drive one command cycle on the selected DUT; returns 1ns after the sampling edge.
  task automatic pulse(input bit on_b, input logic u, input logic dn, input logic ld,
                       input logic sm, input logic [7:0] dv);
    @(negedge clk);
    if (on_b) begin
      bus_b.up = u; bus_b.down = dn; bus_b.load = ld; bus_b.sat_mode = sm; bus_b.D = dv;
    end else begin
      bus_a.up = u; bus_a.down = dn; bus_a.load = ld; bus_a.sat_mode = sm; bus_a.D = dv;
    end
    @(posedge clk); #1;
    bus_a.up = 1'b0; bus_a.down = 1'b0; bus_a.load = 1'b0;
    bus_b.up = 1'b0; bus_b.down = 1'b0; bus_b.load = 1'b0;
  endtask

  // Bounded wait for bcd_valid on the selected DUT.
  task automatic wait_valid(input bit on_b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if ((on_b ? bus_b.bcd_valid : bus_a.bcd_valid) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic reset_on();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic reset_off();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_on();
    n_vec++; if (bus_a.count !== 8'd0) begin n_err++;
      $display("FAIL reset_count: got %0d want 0", bus_a.count); end
    n_vec++; if (bus_a.bcd !== 12'h000) begin n_err++;
      $display("FAIL reset_bcd: got %h want 000", bus_a.bcd); end
    n_vec++; if ({bus_a.bcd_valid, bus_a.ovf, bus_a.unf} !== 3'b100) begin n_err++;
      $display("FAIL reset_flags: got %b want 100", {bus_a.bcd_valid, bus_a.ovf, bus_a.unf}); end
    n_vec++; if (bus_a.digit_fields !== 18'b000001_000001_100001) begin n_err++;
      $display("FAIL reset_fields: got %b want 000001000001100001", bus_a.digit_fields); end
    n_vec++; if (bus_b.count !== 8'd0 || bus_b.bcd_valid !== 1'b1) begin n_err++;
      $display("FAIL reset_b: got count %0d valid %b want 0 1", bus_b.count, bus_b.bcd_valid); end
    reset_off();
  endtask

  task automatic test_count_up();
    bit ok;
    logic [11:0] e;
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    sb_q.push_back(12'h003);
    repeat (12) @(posedge clk);
    wait_valid(1'b0, ok);
    n_vec++; if (!ok) begin n_err++;
      $display("FAIL up3_valid_timeout: got valid 0 want 1"); end
    e = sb_q.pop_front();
    n_vec++; if (bus_a.bcd !== e) begin n_err++;
      $display("FAIL up3_bcd: got %h want %h", bus_a.bcd, e); end
    n_vec++; if (bus_a.count !== 8'd3) begin n_err++;
      $display("FAIL up3_count: got %0d want 3", bus_a.count); end
    n_vec++; if (bus_a.digit_fields !== 18'b000001_000001_100111) begin n_err++;
      $display("FAIL up3_fields: got %b want 000001000001100111", bus_a.digit_fields); end
  endtask

  task automatic test_load_clamp_wrap_sat();
    bit ok;
    logic [11:0] e;
    pulse(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd200);
    n_vec++; if (bus_b.count !== 8'd150 || bus_b.ovf !== 1'b0) begin n_err++;
      $display("FAIL load_clamp: got %0d ovf %b want 150 0", bus_b.count, bus_b.ovf); end
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    n_vec++; if (bus_b.count !== 8'd0 || bus_b.ovf !== 1'b1) begin n_err++;
      $display("FAIL up_wrap: got %0d ovf %b want 0 1", bus_b.count, bus_b.ovf); end
    @(posedge clk); #1;
    n_vec++; if (bus_b.ovf !== 1'b0) begin n_err++;
      $display("FAIL ovf_width_wrap: got %b want 0", bus_b.ovf); end
    sb_q.push_back(12'h000);
    wait_valid(1'b1, ok);
    e = sb_q.pop_front();
    n_vec++; if (!ok || bus_b.bcd !== e) begin n_err++;
      $display("FAIL wrap_bcd: got %h valid %b want %h", bus_b.bcd, ok, e); end
    pulse(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd200);
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    n_vec++; if (bus_b.count !== 8'd150 || bus_b.ovf !== 1'b1) begin n_err++;
      $display("FAIL up_sat: got %0d ovf %b want 150 1", bus_b.count, bus_b.ovf); end
    @(posedge clk); #1;
    n_vec++; if (bus_b.ovf !== 1'b0 || bus_b.count !== 8'd150) begin n_err++;
      $display("FAIL ovf_width_sat: got ovf %b count %0d want 0 150", bus_b.ovf, bus_b.count); end
    sb_q.push_back(12'h150);
    wait_valid(1'b1, ok);
    e = sb_q.pop_front();
    n_vec++; if (!ok || bus_b.bcd !== e) begin n_err++;
      $display("FAIL sat_bcd: got %h valid %b want %h", bus_b.bcd, ok, e); end
    n_vec++; if (bus_b.digit_fields !== 18'b100011_101011_100001) begin n_err++;
      $display("FAIL sat_fields: got %b want 100011101011100001", bus_b.digit_fields); end
  endtask

  task automatic test_down_wrap();
    logic [11:0] e;
    reset_on();
    reset_off();
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    n_vec++; if (bus_a.count !== 8'd255 || bus_a.unf !== 1'b1) begin n_err++;
      $display("FAIL down_wrap: got %0d unf %b want 255 1", bus_a.count, bus_a.unf); end
    sb_q.push_back(12'h255);
    @(posedge clk); #1;
    n_vec++; if (bus_a.unf !== 1'b0) begin n_err++;
      $display("FAIL unf_width: got %b want 0", bus_a.unf); end
    repeat (8) @(posedge clk);
    #1;
    n_vec++; if (bus_a.bcd_valid !== 1'b0) begin n_err++;
      $display("FAIL latency_early: got valid %b want 0 at edge 9", bus_a.bcd_valid); end
    @(posedge clk); #1;
    e = sb_q.pop_front();
    n_vec++; if (bus_a.bcd_valid !== 1'b1 || bus_a.bcd !== e) begin n_err++;
      $display("FAIL latency_10: got %h valid %b want %h 1", bus_a.bcd, bus_a.bcd_valid, e); end
    n_vec++; if (bus_a.digit_fields !== 18'b100101_101011_101011) begin n_err++;
      $display("FAIL fields_255: got %b want 100101101011101011", bus_a.digit_fields); end
  endtask

  task automatic test_up_down_together();
    bit ok;
    logic [11:0] e;
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd7);
    sb_q.push_back(12'h007);
    wait_valid(1'b0, ok);
    e = sb_q.pop_front();
    n_vec++; if (!ok || bus_a.bcd !== e) begin n_err++;
      $display("FAIL load7_bcd: got %h valid %b want %h", bus_a.bcd, ok, e); end
    pulse(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    n_vec++; if ({bus_a.count, bus_a.ovf, bus_a.unf} !== {8'd7, 2'b00}) begin n_err++;
      $display("FAIL updown_hold: got %0d %b%b want 7 00", bus_a.count, bus_a.ovf, bus_a.unf); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (bus_a.bcd_valid !== 1'b1) begin n_err++;
        $display("FAIL updown_valid: got %b want 1 (cycle %0d)", bus_a.bcd_valid, i); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] prev, e;
    bit done;
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd20);
    sb_q.push_back(12'h020);
    @(posedge clk); @(posedge clk);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    sb_q.push_back(12'h021);
    prev = bus_a.bcd;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if (bus_a.bcd !== prev) begin
        prev = bus_a.bcd;
        n_vec++;
        if (sb_q.size() == 0) begin n_err++;
          $display("FAIL b2b_extra_write: got %h want no write", bus_a.bcd);
        end else begin
          e = sb_q.pop_front();
          if (bus_a.bcd !== e) begin n_err++;
            $display("FAIL b2b_order: got %h want %h", bus_a.bcd, e); end
        end
      end
      if (bus_a.bcd_valid === 1'b1) begin
        done = 1'b1;
        n_vec++; if (bus_a.bcd !== 12'h021) begin n_err++;
          $display("FAIL b2b_valid_early: got %h want 021", bus_a.bcd); end
      end
    end
    n_vec++; if (!done || sb_q.size() != 0) begin n_err++;
      $display("FAIL b2b_complete: got done %b pending %0d want 1 0", done, sb_q.size()); end
  endtask

  task automatic test_reset_mid_shift();
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd99);
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (bus_a.bcd_valid !== 1'b0 || bus_a.count !== 8'd99) begin n_err++;
      $display("FAIL pre_rst: got valid %b count %0d want 0 99", bus_a.bcd_valid, bus_a.count); end
    reset_on();
    n_vec++; if (bus_a.count !== 8'd0 || bus_a.bcd !== 12'h000) begin n_err++;
      $display("FAIL rst_mid: got count %0d bcd %h want 0 000", bus_a.count, bus_a.bcd); end
    n_vec++; if (bus_a.bcd_valid !== 1'b1 || bus_a.digit_fields !== 18'b000001_000001_100001)
      begin n_err++;
      $display("FAIL rst_mid_view: got valid %b fields %b want 1 000001000001100001",
               bus_a.bcd_valid, bus_a.digit_fields); end
    reset_off();
    repeat (12) @(posedge clk);
    #1;
    n_vec++; if (bus_a.bcd_valid !== 1'b1 || bus_a.bcd !== 12'h000) begin n_err++;
      $display("FAIL rst_idle: got valid %b bcd %h want 1 000", bus_a.bcd_valid, bus_a.bcd); end
  endtask

  initial begin
    bus_a.up = 1'b0; bus_a.down = 1'b0; bus_a.load = 1'b0; bus_a.sat_mode = 1'b0; bus_a.D = '0;
    bus_b.up = 1'b0; bus_b.down = 1'b0; bus_b.load = 1'b0; bus_b.sat_mode = 1'b0; bus_b.D = '0;
    test_reset();
    test_count_up();
    test_load_clamp_wrap_sat();
    test_down_wrap();
    test_up_down_together();
    test_back_to_back();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mod_counter_bcd.md
Name: mod_counter_bcd

Overview:
- Parametrised up/down/load counter for the board-level counter applications.
- Has a programmable modulus and a selectable wrap or saturate mode.
- Includes a sequential shift-add-3 binary-to-BCD converter, so no wide combinational converter is needed.
- Emits per-digit 6-bit display fields in the sseg_driver input format {enable, bcd[3:0], dp_n}.
- Sits between the debounced button pulses and sseg_driver.

Parameters:
- WIDTH, 8: counter and load-data width in bits.
- MAX, 255: top count value, 1 <= MAX <= 2**WIDTH-1. Legal counts are 0..MAX.
- DIGITS, 3: BCD digits produced. Requires 10**DIGITS > MAX; violation is an elaboration error.
- BLANK_LZ, 1: 1 clears the enable bit of leading-zero digits.

Ports:
- clk, in, 1: system clock; all state changes on the rising edge.
- rst, in, 1: synchronous reset, active-high.
- up, in, 1: single-cycle increment pulse, already debounced.
- down, in, 1: single-cycle decrement pulse, already debounced.
- load, in, 1: single-cycle load pulse, already debounced.
- sat_mode, in, 1: 0 = wrap at the bounds, 1 = saturate at the bounds.
- D, in, WIDTH: load value.
- count, out, WIDTH: current count.
- ovf, out, 1: one-cycle pulse on an up event at MAX.
- unf, out, 1: one-cycle pulse on a down event at 0.
- bcd, out, 4*DIGITS: last completed conversion; digit 0 = ones, in bits [3:0].
- bcd_valid, out, 1: high when bcd corresponds to the current count.
- digit_fields, out, 6*DIGITS: field i = {en_i, bcd digit i, 1'b1}, in bits [6i+5:6i].

Behaviour:
- Reset (rst=1 at an edge), regardless of state or an in-flight conversion:
  - count=0, bcd=0, bcd_valid=1, ovf=0, unf=0.
  - Converter returns to IDLE with snapshot=0.
  - digit_fields shows "0" with digit 0 enabled.
- Counter priority per edge:
  1. load: count <= min(D, MAX). A clamp is not a wrap, so no ovf.
  2. up & down together, no load: hold, no flags.
  3. up only:
     - count<MAX: count+1.
     - count==MAX, wrap mode: count becomes 0, ovf=1.
     - count==MAX, sat mode: hold at MAX, ovf=1.
  4. down only:
     - count>0: count-1.
     - count==0, wrap mode: count becomes MAX, unf=1.
     - count==0, sat mode: hold at 0, unf=1.
- Counter timing and flags:
  - Count update latency is 1 clock.
  - ovf and unf are registered and high only for the cycle after the event edge.
  - sat_mode is sampled on the event edge.
- Converter FSM states and transitions:
  - IDLE: if count != snapshot, load snapshot <= count, clear the shift registers, go to SHIFT. Otherwise stay.
  - SHIFT: WIDTH cycles, MSB first. Before each shift, add 3 to every BCD nibble >= 5. Bit counter ends at WIDTH-1, then go to DONE.
  - DONE: bcd <= result (single registered write), then return to IDLE.
- Converter latency and validity:
  - A count change at edge E gives the matching bcd at edge E+WIDTH+2 (10 clocks for WIDTH=8), if count is stable meanwhile.
  - bcd_valid = (state==IDLE) & (snapshot==count). It is combinational from registers and drops the cycle after any count change.
  - A count change mid-conversion does not abort the conversion. The stale result is written in DONE, then IDLE sees the mismatch and restarts.
  - bcd never shows a partial shift result.
- Display fields:
  - en_0 = 1 always.
  - For i>0: en_i = 1 if BLANK_LZ==0, or if any digit j>=i is non-zero.
  - dp_n = 1 (point off) for all digits.

Decomposition:
- Package mod_counter_pkg holds:
  - The FSM state typedef (IDLE, SHIFT, DONE).
  - The constant SSEG_FIELD_W = 6.
  - A function for the minimum digit count, used for the DIGITS elaboration check.
- Sub-module bin2bcd_seq (WIDTH, DIGITS) contains the IDLE/SHIFT/DONE FSM and exposes bcd and busy.
- The counter and the display-field logic stay in the top level.

Test Plan:
1. Reset, then 3 up pulses, then 12 idle clocks -> count=3; bcd=12'h003; bcd_valid=1; digit_fields enables = 1,0,0.
2. Load D=8'd200 with MAX=150 -> count=150 next cycle, no ovf. Then up in wrap mode -> count=0 and a single ovf pulse. Repeat in sat mode -> count stays 150, ovf pulses.
3. count=0, down in wrap mode -> count=MAX (255 default), unf=1 for 1 cycle. After 10 clocks, bcd=12'h255.
4. up & down asserted together at count=7 -> count stays 7, no flags, no conversion started (bcd_valid stays 1).
5. up pulse 3 cycles after a previous change (mid-conversion) -> stale bcd written first, then a restart. Final bcd matches the new count, with bcd_valid low until then.
6. Assert rst during SHIFT with count=99 -> next cycle count=0, bcd=0, bcd_valid=1, FSM in IDLE.
